// File: rtl/inst_fetch_pkg.sv
// Types and constants shared by the fetch stage and the instruction decoder.
package inst_fetch_pkg;

  localparam int cXLEN = 32;
  localparam logic [cXLEN-1:0] cNop = 32'h0000_0013;

  typedef struct packed {
    logic [cXLEN-1:0] pc;
    logic [cXLEN-1:0] inst;
  } fetchPkt_t;

  function automatic logic [cXLEN-1:0] word_align(input logic [cXLEN-1:0] addr);
    return {addr[cXLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch packets with a registered head entry; when empty the
// head shows a NOP and keeps the PC of the last entry it presented.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [cXLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   iClk,
  input  logic                   iRstN,
  input  logic                   push,
  input  fetchPkt_t              push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output fetchPkt_t              head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  fetchPkt_t     mem_r [DEPTH];
  fetchPkt_t     head_r, head_s;
  logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
  logic [AW:0]   count_r, count_s;
  logic          do_push_s, do_pop_s;

  // Next pointers, occupancy and the head entry the output register will hold.
  always_comb begin
    do_pop_s  = pop & (count_r != CNT_ZERO);
    do_push_s = push & ((count_r != CNT_FULL) | do_pop_s);
    rd_ptr_s  = rd_ptr_r;
    wr_ptr_s  = wr_ptr_r;
    count_s   = count_r;
    head_s    = head_r;
    if (clear) begin
      rd_ptr_s = '0;
      wr_ptr_s = '0;
      count_s  = CNT_ZERO;
      head_s   = {head_r.pc, cNop};
    end else begin
      rd_ptr_s = do_pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
      wr_ptr_s = do_push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
      count_s  = count_r + (do_push_s ? CNT_ONE : CNT_ZERO) - (do_pop_s ? CNT_ONE : CNT_ZERO);
      // The next head may be the word being written this very cycle.
      if (count_s == CNT_ZERO) begin
        head_s = {head_r.pc, cNop};
      end else if (do_push_s && (rd_ptr_s == wr_ptr_r)) begin
        head_s = push_data;
      end else begin
        head_s = mem_r[rd_ptr_s];
      end
    end
  end

  // Storage, pointers and the registered head.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= CNT_ZERO;
      head_r   <= {RESET_PC, cNop};
    end else begin
      if (do_push_s && !clear) mem_r[wr_ptr_r] <= push_data;
      rd_ptr_r <= rd_ptr_s;
      wr_ptr_r <= wr_ptr_s;
      count_r  <= count_s;
      head_r   <= head_s;
    end
  end

  assign count = count_r;
  assign empty = (count_r == CNT_ZERO);
  assign full  = (count_r == CNT_FULL);
  assign head  = head_r;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues in-order instruction reads under a credit limit,
// buffers {pc, inst} for the decoder and discards responses made stale by a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [cXLEN-1:0] cResetPC   = 32'h0000_0000,
  parameter int               cFifoDepth = 4
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iFlushPipe,
  input  logic [cXLEN-1:0] iBranchTarget,
  output logic             oImemReqValid,
  input  logic             iImemReqReady,
  output logic [cXLEN-1:0] oImemAddr,
  input  logic             iImemRspValid,
  input  logic [cXLEN-1:0] iImemRspData,
  output logic             oInstValid,
  input  logic             iInstReady,
  output logic [cXLEN-1:0] oInst,
  output logic [cXLEN-1:0] oCurPC
);

  localparam int CW = $clog2(cFifoDepth) + 1;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]    CNT_ZERO = CW'(1'b0);
  localparam logic [CW:0]      CREDITS  = (CW+1)'(cFifoDepth);
  localparam logic [cXLEN-1:0] PC_STEP  = cXLEN'(3'd4);

  logic [cXLEN-1:0] pc_r;
  logic [CW-1:0]    outstanding_r, drop_r, outstanding_s;
  logic             run_r;
  logic [CW:0]      credit_sum_s;
  logic             req_valid_s, accept_s, keep_s, discard_s;
  logic             data_push_s, data_pop_s, tag_pop_s;
  logic [CW-1:0]    data_count_s, tag_count_s;
  logic             data_empty_s, data_full_s, tag_empty_s, tag_full_s;
  fetchPkt_t        rsp_pkt_s, tag_pkt_s, data_head_s, tag_head_s;

  // Issue credit, response classification and FIFO controls; a flush overrides all of them.
  always_comb begin
    credit_sum_s  = {1'b0, data_count_s} + {1'b0, outstanding_r};
    req_valid_s   = run_r & ~iFlushPipe & (credit_sum_s < CREDITS);
    accept_s      = req_valid_s & iImemReqReady;
    keep_s        = iImemRspValid & (drop_r == CNT_ZERO);
    discard_s     = iImemRspValid & (drop_r != CNT_ZERO);
    outstanding_s = outstanding_r + (accept_s ? CNT_ONE : CNT_ZERO)
                                  - (iImemRspValid ? CNT_ONE : CNT_ZERO);
    data_push_s   = keep_s & ~iFlushPipe;
    data_pop_s    = ~data_empty_s & iInstReady & ~iFlushPipe;
    tag_pop_s     = keep_s & ~iFlushPipe;
    rsp_pkt_s     = {tag_head_s.pc, iImemRspData};
    // The inverted PC copy lets the tag entry be integrity-checked on the way out.
    tag_pkt_s     = {pc_r, ~pc_r};
  end

  // PC, in-flight and drop counters; a flush turns every unanswered read into a drop.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pc_r          <= cResetPC;
      outstanding_r <= CNT_ZERO;
      drop_r        <= CNT_ZERO;
      run_r         <= 1'b0;
    end else begin
      run_r         <= 1'b1;
      outstanding_r <= outstanding_s;
      if (iFlushPipe) begin
        pc_r   <= word_align(iBranchTarget);
        drop_r <= outstanding_s;
      end else begin
        if (accept_s)  pc_r   <= pc_r + PC_STEP;
        if (discard_s) drop_r <= drop_r - CNT_ONE;
      end
    end
  end

  fetch_fifo #(.DEPTH(cFifoDepth), .RESET_PC(cResetPC)) u_data_fifo (
    .iClk(iClk), .iRstN(iRstN), .push(data_push_s), .push_data(rsp_pkt_s),
    .pop(data_pop_s), .clear(iFlushPipe), .count(data_count_s),
    .empty(data_empty_s), .full(data_full_s), .head(data_head_s)
  );

  fetch_fifo #(.DEPTH(cFifoDepth), .RESET_PC(cResetPC)) u_tag_fifo (
    .iClk(iClk), .iRstN(iRstN), .push(accept_s), .push_data(tag_pkt_s),
    .pop(tag_pop_s), .clear(iFlushPipe), .count(tag_count_s),
    .empty(tag_empty_s), .full(tag_full_s), .head(tag_head_s)
  );

  assign oImemReqValid = req_valid_s;
  assign oImemAddr     = pc_r;
  assign oInstValid    = ~data_empty_s;
  assign oInst         = data_head_s.inst;
  assign oCurPC        = data_head_s.pc;

  a_no_full_push: assert property (@(posedge iClk) disable iff (!iRstN)
    !(data_push_s && data_full_s));
  a_no_rsp_underflow: assert property (@(posedge iClk) disable iff (!iRstN)
    !(iImemRspValid && (outstanding_r == CNT_ZERO)));
  a_tag_room: assert property (@(posedge iClk) disable iff (!iRstN)
    !(accept_s && tag_full_s));
  a_tag_present: assert property (@(posedge iClk) disable iff (!iRstN)
    !(keep_s && tag_empty_s));
  a_tag_count: assert property (@(posedge iClk) disable iff (!iRstN)
    tag_count_s <= outstanding_r);
  a_tag_intact: assert property (@(posedge iClk) disable iff (!iRstN)
    tag_empty_s || (tag_head_s.inst == ~tag_head_s.pc));

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: an in-order memory with variable latency, a
// random decoder, and a stream-level reference model of what must be delivered.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, req_v, req_rdy, rsp_v, inst_v, inst_rdy;
  logic [31:0] tgt, addr, rsp_d, inst, cur_pc;
  logic        w_req_v, w_inst_v;
  logic [31:0] w_addr, w_inst, w_pc;

  inst_fetch dut (
    .iClk(clk), .iRstN(rst_n), .iFlushPipe(flush), .iBranchTarget(tgt),
    .oImemReqValid(req_v), .iImemReqReady(req_rdy), .oImemAddr(addr),
    .iImemRspValid(rsp_v), .iImemRspData(rsp_d),
    .oInstValid(inst_v), .iInstReady(inst_rdy), .oInst(inst), .oCurPC(cur_pc)
  );

  inst_fetch #(.cResetPC(32'hFFFF_FFF8)) dut_w (
    .iClk(clk), .iRstN(rst_n), .iFlushPipe(1'b0), .iBranchTarget(32'h0000_0000),
    .oImemReqValid(w_req_v), .iImemReqReady(1'b1), .oImemAddr(w_addr),
    .iImemRspValid(1'b0), .iImemRspData(32'h0000_0000),
    .oInstValid(w_inst_v), .iInstReady(1'b1), .oInst(w_inst), .oCurPC(w_pc)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  int lat_lo = 1, lat_hi = 1, mrdy_pct = 100, drdy_pct = 100, flush_pct = 0;
  // memory: accepted addresses and the cycle each response becomes due
  logic [31:0] mq[$];
  int          dq[$];
  // model: unanswered reads, buffered entries, reads still to discard, next PCs
  int          m_out, m_buf, m_drop;
  logic [31:0] m_req_pc, m_exp_pc;
  bit          last_flush;
  // directed bookkeeping
  int          acc_cnt, first_acc_cyc, first_val_cyc, w_idx;
  bit          watch, seen_addr, seen_pc;
  logic [31:0] addr_after, pc_after;
  logic [31:0] wrap_exp [3];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic [31:0] rst_pc);
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; rsp_v = 1'b0; req_rdy = 1'b0; inst_rdy = 1'b0;
    tgt = 32'h0000_0000; rsp_d = 32'h0000_0000;
    #1;
    chk("rst_req_valid", req_v, 32'd0);
    chk("rst_inst_valid", inst_v, 32'd0);
    chk("rst_inst", inst, cNop);
    chk("rst_pc", cur_pc, rst_pc);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFF8);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); dq.delete();
    m_out = 0; m_buf = 0; m_drop = 0; last_flush = 1'b0;
    m_req_pc = rst_pc; m_exp_pc = rst_pc;
    acc_cnt = 0; first_acc_cyc = -1; first_val_cyc = -1;
  endtask

  task automatic step(input bit fflush, input logic [31:0] ftgt);
    bit pv, acc, cons, fl;
    @(negedge clk);
    cyc++;
    fl = fflush || (flush_pct > 0 && !last_flush && $urandom_range(99) < flush_pct);
    flush    = fl;
    tgt      = fflush ? ftgt : $urandom;
    req_rdy  = ($urandom_range(99) < mrdy_pct);
    inst_rdy = ($urandom_range(99) < drdy_pct);
    if (dq.size() > 0 && dq[0] <= cyc) begin
      rsp_v = 1'b1; rsp_d = mem_word(mq[0]);
    end else begin
      rsp_v = 1'b0; rsp_d = $urandom;
    end
    #1;
    pv = !fl && (m_buf + m_out < 4);
    chk("req_valid", req_v, pv);
    if (pv) chk("req_addr", addr, m_req_pc);
    chk("inst_valid", inst_v, m_buf > 0);
    if (m_buf > 0) begin
      chk("cur_pc", cur_pc, m_exp_pc);
      chk("inst", inst, mem_word(m_exp_pc));
    end else begin
      chk("idle_nop", inst, cNop);
    end
    if (w_req_v && w_idx < 3) begin
      chk("wrap_addr", w_addr, wrap_exp[w_idx]);
      w_idx++;
    end
    // observations of the DUT for the directed scenarios
    if (req_v && req_rdy) begin
      acc_cnt++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      if (watch && !seen_addr) begin seen_addr = 1'b1; addr_after = addr; end
      mq.push_back(addr);
      dq.push_back(cyc + $urandom_range(lat_hi, lat_lo));
    end
    if (inst_v && first_val_cyc < 0) first_val_cyc = cyc;
    if (inst_v && watch && !seen_pc) begin seen_pc = 1'b1; pc_after = cur_pc; end
    if (rsp_v) begin void'(mq.pop_front()); void'(dq.pop_front()); end
    // reference model advances to the state after this clock edge
    acc  = pv && req_rdy;
    cons = (m_buf > 0) && inst_rdy && !fl;
    if (rsp_v) m_out--;
    if (acc) m_out++;
    if (fl) begin
      m_buf = 0; m_drop = m_out;
      m_req_pc = {tgt[31:2], 2'b00}; m_exp_pc = {tgt[31:2], 2'b00};
    end else begin
      if (rsp_v) begin
        if (m_drop > 0) m_drop--; else m_buf++;
      end
      if (cons) begin m_buf--; m_exp_pc = m_exp_pc + 32'd4; end
      if (acc) m_req_pc = m_req_pc + 32'd4;
    end
    last_flush = fl;
  endtask

  initial begin
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
    w_idx = 0; watch = 1'b0;
    rst_n = 1'b1; flush = 1'b0; req_rdy = 1'b0; rsp_v = 1'b0; inst_rdy = 1'b0;
    tgt = 32'h0000_0000; rsp_d = 32'h0000_0000;

    // streaming from reset: 1-cycle memory, decoder always ready
    do_reset(32'h0000_0000);
    step(1'b0, 32'h0); step(1'b0, 32'h0); step(1'b0, 32'h0);
    chk("first_pc", cur_pc, 32'h0000_0000);
    chk("first_inst", inst, 32'h1357_2468);
    step(1'b0, 32'h0);
    chk("second_pc", cur_pc, 32'h0000_0004);
    chk("second_inst", inst, 32'h6B8A_C2AC);
    repeat (16) step(1'b0, 32'h0);
    chk("fetch_latency", first_val_cyc - first_acc_cyc, 32'd2);

    // decoder back-pressure from empty
    do_reset(32'h0000_0000);
    drdy_pct = 0;
    repeat (10) step(1'b0, 32'h0);
    chk("bp_accepts", acc_cnt, 32'd4);
    drdy_pct = 100;
    repeat (20) step(1'b0, 32'h0);

    // redirect with three reads in flight
    do_reset(32'h0000_0000);
    lat_lo = 3; lat_hi = 3;
    repeat (3) step(1'b0, 32'h0);
    chk("pre_flush_accepts", acc_cnt, 32'd3);
    step(1'b1, 32'h0000_0102);
    watch = 1'b1; seen_addr = 1'b0; seen_pc = 1'b0;
    repeat (15) step(1'b0, 32'h0);
    watch = 1'b0;
    chk("redirect_addr", addr_after, 32'h0000_0100);
    chk("redirect_pc", pc_after, 32'h0000_0100);

    // redirect in the same cycle as a response and a pop
    do_reset(32'h0000_0000);
    lat_lo = 1; lat_hi = 1;
    repeat (4) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0200);
    step(1'b0, 32'h0);
    chk("flush_empty", inst_v, 32'd0);
    repeat (20) step(1'b0, 32'h0);
    chk("wrap_count", w_idx, 32'd3);

    // random latency, readiness and redirects, with a reset in the middle
    lat_lo = 1; lat_hi = 6; mrdy_pct = 70; drdy_pct = 60; flush_pct = 3;
    repeat (5000) step(1'b0, 32'h0);
    do_reset(32'h0000_0000);
    repeat (5000) step(1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
